// File: rtl/instr_fetch.sv
// instr_fetch: fetch PC, credit-limited imem requests and an in-order prefetch FIFO with redirect flush.
// Define INSTR_FETCH_ALIGN_CHECK_EN to halt with a sticky misalign flag on misaligned redirects.
module instr_fetch #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int DEPTH = 4
) (
  input  logic        clk,
  input  logic        reset,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_gnt,
  input  logic        imem_rvalid,
  input  logic [31:0] imem_rdata,
  output logic [31:0] instr,
  output logic [31:0] instr_pc,
  output logic        instr_valid,
  input  logic        instr_ready,
  input  logic        redirect,
  input  logic [31:0] redirect_pc,
  output logic        misalign
);
  localparam int CW = $clog2(DEPTH + 1);
  localparam int AW = $clog2(DEPTH);
  localparam logic [CW:0] LIM = (CW+1)'(DEPTH);
  typedef enum logic [1:0] {BOOT, FETCH, HALT} state_t;
  state_t state, state_n;
  logic [31:0] pc, pc_r;
  logic [CW-1:0] outstanding, count, drop;
  logic [AW-1:0] rd, wr, trd, twr;
  logic [31:0] dmem [DEPTH];
  logic [31:0] pmem [DEPTH];
  logic [31:0] tmem [DEPTH];
  logic issue, push, pop, bad;
`ifdef INSTR_FETCH_ALIGN_CHECK_EN
  assign bad  = redirect && redirect_pc[1:0] != 2'b00;
  assign pc_r = redirect_pc;
  always_ff @(posedge clk or posedge reset)
    if (reset) misalign <= 1'b0;
    else if (bad) misalign <= 1'b1;
`else
  assign bad      = 1'b0;
  assign pc_r     = redirect_pc & 32'hFFFF_FFFC;
  assign misalign = 1'b0;
`endif
  assign imem_req    = state == FETCH && !redirect && ({1'b0, outstanding} + {1'b0, count} < LIM);
  assign imem_addr   = pc;
  assign issue       = imem_req && imem_gnt;
  assign push        = imem_rvalid && drop == '0 && !redirect;
  assign instr_valid = count != '0;
  assign pop         = instr_valid && instr_ready;
  assign instr       = instr_valid ? dmem[rd] : '0;
  assign instr_pc    = instr_valid ? pmem[rd] : '0;
  always_ff @(posedge clk or posedge reset)
    if (reset) state <= BOOT;
    else state <= state_n;
  always_comb state_n = bad ? HALT : state == BOOT ? FETCH : state;
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      pc          <= RESET_PC;
      outstanding <= '0;
      count       <= '0;
      drop        <= '0;
      rd          <= '0;
      wr          <= '0;
      trd         <= '0;
      twr         <= '0;
    end else begin
      outstanding <= outstanding + CW'(issue) - CW'(imem_rvalid);
      if (redirect) begin
        // a response landing in the redirect cycle is already stale, so it is not counted in drop
        pc    <= pc_r;
        drop  <= outstanding - CW'(imem_rvalid);
        count <= '0;
        rd    <= '0;
        wr    <= '0;
        trd   <= '0;
        twr   <= '0;
      end else begin
        if (issue) begin
          pc  <= pc + 32'd4;
          twr <= twr + AW'(1);
        end
        if (imem_rvalid && drop != '0) drop <= drop - CW'(1);
        if (push) begin
          wr  <= wr + AW'(1);
          trd <= trd + AW'(1);
        end
        if (pop) rd <= rd + AW'(1);
        count <= count + CW'(push) - CW'(pop);
      end
    end
  always_ff @(posedge clk) begin
    if (issue) tmem[twr] <= pc;
    if (push) begin
      dmem[wr] <= imem_rdata;
      pmem[wr] <= tmem[trd];
    end
  end
endmodule

// File: tb/tb_instr_fetch.sv
// tb_instr_fetch: directed tests with a latency-configurable memory model and an expected-PC scoreboard.
module tb_instr_fetch;
  logic clk = 1'b0, reset = 1'b0;
  logic imem_req, imem_gnt = 1'b0, imem_rvalid = 1'b0;
  logic [31:0] imem_addr, imem_rdata = 32'h0;
  logic [31:0] instr, instr_pc;
  logic instr_valid, instr_ready = 1'b0, redirect = 1'b0, misalign;
  logic [31:0] redirect_pc = 32'h0;
  int errs = 0, nchk = 0, lat = 1, ngnt = 0, ncyc = 0, mcyc = 0;
  int first_pop = -1, last_pop = -1, npop = 0;
  logic [31:0] expq[$];
  typedef struct {logic [31:0] a; int due;} rsp_t;
  rsp_t pend[$];

  instr_fetch dut (
    .clk(clk), .reset(reset), .imem_req(imem_req), .imem_addr(imem_addr), .imem_gnt(imem_gnt),
    .imem_rvalid(imem_rvalid), .imem_rdata(imem_rdata), .instr(instr), .instr_pc(instr_pc),
    .instr_valid(instr_valid), .instr_ready(instr_ready), .redirect(redirect),
    .redirect_pc(redirect_pc), .misalign(misalign)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] memf(input logic [31:0] a);
    return {a[7:0], a[31:8]} ^ 32'h5A5A_1234;
  endfunction

  task automatic chk(input string n, input logic [31:0] a, input logic [31:0] e);
    nchk++;
    if (a !== e) begin
      errs++;
      $display("FAIL %s got=%h exp=%h", n, a, e);
    end
  endtask

  // memory: grants seen at a negedge complete at the following edge; the response is driven lat cycles later
  initial forever begin
    rsp_t r;
    @(negedge clk);
    ncyc++;
    if (reset) begin
      pend.delete();
      imem_rvalid = 1'b0;
    end else begin
      if (pend.size() > 0 && pend[0].due <= ncyc) begin
        r = pend.pop_front();
        imem_rvalid = 1'b1;
        imem_rdata  = memf(r.a);
      end else begin
        imem_rvalid = 1'b0;
        imem_rdata  = 32'hBAD0_0000;
      end
      if (imem_req && imem_gnt) begin
        pend.push_back('{imem_addr, ncyc + lat});
        ngnt++;
      end
    end
  end

  // monitor: every accepted instruction is compared with the head of the expected queue
  initial forever begin
    logic [31:0] e;
    @(negedge clk);
    mcyc++;
    if (!reset && instr_valid && instr_ready) begin
      npop++;
      if (first_pop < 0) first_pop = mcyc;
      last_pop = mcyc;
      if (expq.size() == 0) begin
        nchk++;
        errs++;
        $display("FAIL unexpected_pop pc=%h instr=%h exp=none", instr_pc, instr);
      end else begin
        e = expq.pop_front();
        chk("instr_pc", instr_pc, e);
        chk("instr", instr, memf(e));
      end
    end
  end

  always @(posedge clk)
    if (!reset && dut.push) begin
      nchk++;
      if (int'(dut.count) >= 4) begin
        errs++;
        $display("FAIL fifo_overflow count=%0d exp<4", dut.count);
      end
    end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic expect_seq(input logic [31:0] base, input int n);
    for (int i = 0; i < n; i++) expq.push_back(base + 32'(4 * i));
  endtask

  task automatic do_reset();
    reset = 1'b1;
    imem_gnt = 1'b0;
    instr_ready = 1'b0;
    redirect = 1'b0;
    lat = 1;
    repeat (2) step();
    ngnt = 0;
    npop = 0;
    first_pop = -1;
    expq.delete();
    reset = 1'b0;
  endtask

  task automatic wait_grants(input int n);
    for (int i = 0; i < 50 && ngnt < n; i++) step();
    chk("grant_count", 32'(ngnt), 32'(n));
  endtask

  task automatic wait_drain();
    for (int i = 0; i < 200 && expq.size() > 0; i++) step();
    chk("drain_left", 32'(expq.size()), 32'd0);
    instr_ready = 1'b0;
  endtask

  initial begin
    #1 reset = 1'b1;
    #1;
    chk("rst_req", 32'(imem_req), 32'd0);
    chk("rst_addr", imem_addr, 32'd0);
    chk("rst_valid", 32'(instr_valid), 32'd0);
    chk("rst_instr", instr, 32'd0);
    chk("rst_pc", instr_pc, 32'd0);
    chk("rst_misalign", 32'(misalign), 32'd0);
    // streaming with 1-cycle memory and an always-ready consumer
    expect_seq(32'h0, 16);
    lat = 1;
    imem_gnt = 1'b1;
    instr_ready = 1'b1;
    step();
    reset = 1'b0;
    @(negedge clk);
    chk("boot_req", 32'(imem_req), 32'd0);
    @(negedge clk);
    chk("first_req", 32'(imem_req), 32'd1);
    chk("first_addr", imem_addr, 32'h0);
    @(negedge clk);
    chk("addr1", imem_addr, 32'h4);
    @(negedge clk);
    chk("addr2", imem_addr, 32'h8);
    step();
    wait_drain();
    chk("throughput", 32'(last_pop - first_pop), 32'd15);
    // consumer stalled: credit limits to DEPTH grants
    do_reset();
    imem_gnt = 1'b1;
    repeat (20) step();
    chk("stall_grants", 32'(ngnt), 32'd4);
    chk("stall_req", 32'(imem_req), 32'd0);
    chk("stall_valid", 32'(instr_valid), 32'd1);
    expect_seq(32'h0, 4);
    instr_ready = 1'b1;
    wait_drain();
    // two requests in flight on a 3-cycle memory, then redirect
    do_reset();
    lat = 3;
    imem_gnt = 1'b1;
    instr_ready = 1'b1;
    wait_grants(2);
    imem_gnt = 1'b0;
    redirect = 1'b1;
    redirect_pc = 32'h100;
    @(negedge clk);
    chk("redir_req", 32'(imem_req), 32'd0);
    step();
    redirect = 1'b0;
    imem_gnt = 1'b1;
    chk("redir_addr", imem_addr, 32'h100);
    expect_seq(32'h100, 4);
    wait_drain();
    // redirect together with a response and a pop
    do_reset();
    lat = 2;
    imem_gnt = 1'b1;
    wait_grants(3);
    imem_gnt = 1'b0;
    redirect = 1'b1;
    redirect_pc = 32'h200;
    instr_ready = 1'b1;
    expq.push_back(32'h0);
    @(negedge clk);
    chk("same_rvalid", 32'(imem_rvalid), 32'd1);
    chk("same_valid", 32'(instr_valid), 32'd1);
    step();
    redirect = 1'b0;
    imem_gnt = 1'b1;
    chk("flush_valid", 32'(instr_valid), 32'd0);
    chk("popped_branch", 32'(npop), 32'd1);
    expect_seq(32'h200, 3);
    wait_drain();
    // PC wrap
    do_reset();
    step();
    redirect = 1'b1;
    redirect_pc = 32'hFFFF_FFFC;
    step();
    redirect = 1'b0;
    chk("wrap_addr0", imem_addr, 32'hFFFF_FFFC);
    imem_gnt = 1'b1;
    instr_ready = 1'b1;
    expq.push_back(32'hFFFF_FFFC);
    expect_seq(32'h0, 2);
    step();
    chk("wrap_addr1", imem_addr, 32'h0);
    wait_drain();
    // misaligned redirect
    do_reset();
    step();
    redirect = 1'b1;
    redirect_pc = 32'h102;
    step();
    redirect = 1'b0;
    imem_gnt = 1'b1;
`ifdef INSTR_FETCH_ALIGN_CHECK_EN
    chk("mis_flag", 32'(misalign), 32'd1);
    for (int i = 0; i < 5; i++) begin
      chk("halt_req", 32'(imem_req), 32'd0);
      step();
    end
    redirect = 1'b1;
    redirect_pc = 32'h200;
    step();
    redirect = 1'b0;
    repeat (3) step();
    chk("mis_sticky", 32'(misalign), 32'd1);
    chk("halt_req_after", 32'(imem_req), 32'd0);
    chk("halt_grants", 32'(ngnt), 32'd0);
`else
    chk("mis_flag", 32'(misalign), 32'd0);
    chk("mis_addr", imem_addr, 32'h100);
    instr_ready = 1'b1;
    expect_seq(32'h100, 2);
    wait_drain();
`endif
    $display("Result: errors=%0d of %0d checks", errs, nchk);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog timeout");
    $fatal(1);
  end
endmodule
